// File: rtl/router_input_unit.sv
// Per-input-port front end of the mesh router: flit FIFO, XY route computation
// from the head flit, wormhole route hold and one-hot output-port request.
module router_input_unit #(
  parameter int FlitWidth = 34,
  parameter int Depth     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           position_x,
  input  logic [2:0]           position_y,
  input  logic [FlitWidth-1:0] data_in,
  input  logic                 data_in_valid,
  output logic                 data_in_ready,
  output logic [4:0]           request,
  output logic [FlitWidth-1:0] data_out,
  input  logic [4:0]           grant,
  input  logic [4:0]           out_ready,
  output logic                 forwarding_head,
  output logic                 forwarding_tail,
  output logic                 protocol_error
);

  localparam int PtrW = $clog2(Depth);
  localparam int CntW = PtrW + 1;

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  logic [FlitWidth-1:0] mem_q [Depth];
  logic [FlitWidth-1:0] mem_d [Depth];
  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]      count_q, count_d;
  state_t               state_q, state_d;
  logic [4:0]           route_q, route_d;
  logic                 error_q, error_d;

  logic       front_head, front_tail;
  logic [2:0] dst_x, dst_y;
  logic [4:0] front_route;
  logic       not_empty, full;
  logic       push, pop, fwd, drop;

  assign data_out   = mem_q[rd_ptr_q];
  assign front_head = data_out[FlitWidth-1];
  assign front_tail = data_out[FlitWidth-2];
  assign dst_y      = data_out[FlitWidth-3 -: 3];
  assign dst_x      = data_out[FlitWidth-6 -: 3];

  assign not_empty = (count_q != '0);
  assign full      = (count_q == CntW'(Depth));

  // No write-through: a full FIFO refuses input even in a cycle that pops.
  assign data_in_ready  = ~full & ~rst;
  assign push           = data_in_valid & data_in_ready;
  assign protocol_error = error_q & ~rst;

  // Dimension-ordered routing: resolve X first, then Y, else deliver locally.
  always_comb begin
    front_route = 5'b10000;
    if (dst_x > position_x)      front_route = 5'b01000;
    else if (dst_x < position_x) front_route = 5'b00100;
    else if (dst_y > position_y) front_route = 5'b00010;
    else if (dst_y < position_y) front_route = 5'b00001;
  end

  always_comb begin
    request = '0;
    drop    = 1'b0;
    if (!rst && not_empty) begin
      if (state_q == ACTIVE) begin
        request = route_q;
      end else if (front_head) begin
        request = front_route;
      end else begin
        drop = 1'b1;
      end
    end
  end

  assign fwd             = |(request & grant & out_ready);
  assign pop             = fwd | drop;
  assign forwarding_head = fwd & front_head & (state_q == IDLE);
  assign forwarding_tail = fwd & front_tail;

  always_comb begin
    state_d = state_q;
    route_d = route_q;
    error_d = error_q | drop;
    case (state_q)
      IDLE: begin
        if (fwd && front_head && !front_tail) begin
          route_d = front_route;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (fwd && front_tail) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = data_in;
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      state_q  <= IDLE;
      route_q  <= '0;
      error_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      state_q  <= state_d;
      route_q  <= route_d;
      error_q  <= error_d;
    end
  end

  // Storage needs no reset; the count alone decides which entries are live.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_router_input_unit.sv
// Directed bench for router_input_unit at position (2,2); expected pops are
// queued at stimulus time and checked by a monitor whenever a flit is forwarded.
module tb_router_input_unit;

  logic        clk;
  logic        rst;
  logic [2:0]  position_x, position_y;
  logic [33:0] data_in;
  logic        data_in_valid;
  logic        data_in_ready;
  logic [4:0]  request;
  logic [33:0] data_out;
  logic [4:0]  grant;
  logic [4:0]  out_ready;
  logic        forwarding_head;
  logic        forwarding_tail;
  logic        protocol_error;

  typedef struct packed {
    logic [33:0] data;
    logic [4:0]  req;
    logic        fh;
    logic        ft;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  router_input_unit #(.FlitWidth(34), .Depth(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .position_x      (position_x),
    .position_y      (position_y),
    .data_in         (data_in),
    .data_in_valid   (data_in_valid),
    .data_in_ready   (data_in_ready),
    .request         (request),
    .data_out        (data_out),
    .grant           (grant),
    .out_ready       (out_ready),
    .forwarding_head (forwarding_head),
    .forwarding_tail (forwarding_tail),
    .protocol_error  (protocol_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation did not complete");
  end

  function automatic logic [33:0] mk_flit(input logic h, input logic t,
                                          input logic [2:0] dy, input logic [2:0] dx,
                                          input logic [25:0] payload);
    return {h, t, dy, dx, payload};
  endfunction

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one flit and holds it until accepted; optionally records the expected pop.
  task automatic apply_stimulus(input logic [33:0] f, input logic [4:0] req,
                                input logic fh, input logic ft, input bit track);
    int n = 0;
    data_in       = f;
    data_in_valid = 1'b1;
    if (track) sb.push_back('{data: f, req: req, fh: fh, ft: ft});
    @(negedge clk);
    while (!data_in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!data_in_ready) check_output("push_timeout", 64'(data_in_ready), 64'd1);
    @(posedge clk);
    #1;
    data_in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    check_output(name, 64'(sb.size()), 64'd0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (|(request & grant & out_ready)) begin
        if (sb.size() == 0) begin
          check_output("unexpected_pop", {30'd0, data_out}, 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_output("pop_data", {30'd0, data_out}, {30'd0, e.data});
          check_output("pop_request", {59'd0, request}, {59'd0, e.req});
          check_output("pop_head_pulse", 64'(forwarding_head), 64'(e.fh));
          check_output("pop_tail_pulse", 64'(forwarding_tail), 64'(e.ft));
        end
      end else begin
        check_output("idle_pulses", {62'd0, forwarding_head, forwarding_tail}, 64'd0);
      end
    end
  end

  initial begin
    logic pat [5];
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    rst = 1'b1;
    position_x = 3'd2;
    position_y = 3'd2;
    data_in = '0;
    data_in_valid = 1'b0;
    grant = '0;
    out_ready = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("rst_ready", 64'(data_in_ready), 64'd0);
    check_output("rst_request", 64'(request), 64'd0);
    check_output("rst_error", 64'(protocol_error), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_output("post_rst_ready", 64'(data_in_ready), 64'd1);
    check_output("post_rst_request", 64'(request), 64'd0);
    @(posedge clk);
    #1;

    // 1: single-flit packet to (3,0) leaves East
    apply_stimulus(mk_flit(1, 1, 3'd0, 3'd3, 26'h0A1), 5'b01000, 1, 1, 1);
    @(negedge clk);
    check_output("t1_request_east", 64'(request), 64'b01000);
    @(posedge clk);
    #1 grant = 5'b01000; out_ready = 5'b01000;
    @(posedge clk);
    #1;
    @(negedge clk);
    check_output("t1_empty_request", 64'(request), 64'd0);
    check_output("t1_ready", 64'(data_in_ready), 64'd1);
    @(posedge clk);
    #1 grant = '0; out_ready = '0;

    // 2: four-flit packet to (2,0) goes North, pops only when out_ready[0] is high
    apply_stimulus(mk_flit(1, 0, 3'd0, 3'd2, 26'h200), 5'b00001, 1, 0, 1);
    apply_stimulus(mk_flit(0, 0, 3'd5, 3'd5, 26'h201), 5'b00001, 0, 0, 1);
    apply_stimulus(mk_flit(0, 0, 3'd1, 3'd7, 26'h202), 5'b00001, 0, 0, 1);
    apply_stimulus(mk_flit(0, 1, 3'd2, 3'd2, 26'h203), 5'b00001, 0, 1, 1);
    grant = 5'b00001;
    for (int i = 0; i < 5; i++) begin
      out_ready = {4'b0000, pat[i]};
      @(negedge clk);
      check_output("t2_request_held", 64'(request), 64'b00001);
      @(posedge clk);
      #1;
    end
    grant = '0; out_ready = '0;
    check_output("t2_all_popped", 64'(sb.size()), 64'd0);

    // 3: fill to depth, fifth flit waits; pops free space one cycle later
    apply_stimulus(mk_flit(1, 0, 3'd2, 3'd0, 26'h300), 5'b00100, 1, 0, 1);
    apply_stimulus(mk_flit(0, 0, 3'd0, 3'd0, 26'h301), 5'b00100, 0, 0, 1);
    apply_stimulus(mk_flit(0, 0, 3'd0, 3'd0, 26'h302), 5'b00100, 0, 0, 1);
    apply_stimulus(mk_flit(0, 0, 3'd0, 3'd0, 26'h303), 5'b00100, 0, 0, 1);
    data_in = mk_flit(0, 1, 3'd0, 3'd0, 26'h304);
    data_in_valid = 1'b1;
    sb.push_back('{data: data_in, req: 5'b00100, fh: 1'b0, ft: 1'b1});
    @(negedge clk);
    check_output("t3_full_ready", 64'(data_in_ready), 64'd0);
    check_output("t3_request_west", 64'(request), 64'b00100);
    @(posedge clk);
    #1 grant = 5'b00100; out_ready = 5'b00100;
    @(negedge clk);
    check_output("t3_no_bypass", 64'(data_in_ready), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_output("t3_ready_after_pop", 64'(data_in_ready), 64'd1);
    @(posedge clk);
    #1 data_in_valid = 1'b0;
    wait_drain("t3_drain");
    grant = '0; out_ready = '0;

    // 4: East packet whose later flits decode as Local keeps the East route
    grant = 5'b01000; out_ready = 5'b01000;
    apply_stimulus(mk_flit(1, 0, 3'd2, 3'd4, 26'h400), 5'b01000, 1, 0, 1);
    apply_stimulus(mk_flit(1, 0, 3'd2, 3'd2, 26'h401), 5'b01000, 0, 0, 1);
    apply_stimulus(mk_flit(0, 1, 3'd2, 3'd2, 26'h402), 5'b01000, 0, 1, 1);
    wait_drain("t4_drain");
    grant = '0; out_ready = '0;

    // 5: body flit with no open packet is dropped and latches the error
    apply_stimulus(mk_flit(0, 0, 3'd0, 3'd3, 26'h500), 5'b00000, 0, 0, 0);
    @(negedge clk);
    check_output("t5_no_request", 64'(request), 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_output("t5_error_set", 64'(protocol_error), 64'd1);
    check_output("t5_dropped_request", 64'(request), 64'd0);
    @(posedge clk);
    #1 grant = 5'b00010; out_ready = 5'b00010;
    apply_stimulus(mk_flit(1, 1, 3'd4, 3'd2, 26'h501), 5'b00010, 1, 1, 1);
    wait_drain("t5_drain");
    grant = '0; out_ready = '0;
    @(negedge clk);
    check_output("t5_error_sticky", 64'(protocol_error), 64'd1);
    @(posedge clk);
    #1;

    // 6: reset with an open North packet and two buffered body flits
    grant = 5'b00001; out_ready = 5'b00001;
    apply_stimulus(mk_flit(1, 0, 3'd0, 3'd2, 26'h600), 5'b00001, 1, 0, 1);
    wait_drain("t6_head_drain");
    grant = '0; out_ready = '0;
    apply_stimulus(mk_flit(0, 0, 3'd0, 3'd0, 26'h601), 5'b00000, 0, 0, 0);
    apply_stimulus(mk_flit(0, 0, 3'd0, 3'd0, 26'h602), 5'b00000, 0, 0, 0);
    @(negedge clk);
    check_output("t6_pre_rst_request", 64'(request), 64'b00001);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check_output("t6_rst_ready", 64'(data_in_ready), 64'd0);
    check_output("t6_rst_request", 64'(request), 64'd0);
    check_output("t6_rst_error", 64'(protocol_error), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_output("t6_post_ready", 64'(data_in_ready), 64'd1);
    check_output("t6_post_request", 64'(request), 64'd0);
    check_output("t6_post_error", 64'(protocol_error), 64'd0);
    @(posedge clk);
    #1;
    apply_stimulus(mk_flit(1, 1, 3'd2, 3'd2, 26'h603), 5'b10000, 1, 1, 1);
    @(negedge clk);
    check_output("t6_local_request", 64'(request), 64'b10000);
    @(posedge clk);
    #1 grant = 5'b10000; out_ready = 5'b10000;
    wait_drain("t6_drain");
    grant = '0; out_ready = '0;

    check_output("final_scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/router_input_unit.md
# router_input_unit

Per-input-port front end of the 5-port mesh router. It buffers incoming flits in a small FIFO and computes the XY route from each head flit. It holds that route for the whole packet (wormhole) and raises a one-hot request toward the output-port arbiters. On every forwarded flit it pops the FIFO and emits the head/tail pulses those arbiters use to lock grants and rotate priority.

## Interface
Parameters:
- FlitWidth, 34: flit width in bits.
  - bit FlitWidth-1 = head; bit FlitWidth-2 = tail; both set = single-flit packet.
  - [FlitWidth-3 -: 3] = destination y; [FlitWidth-6 -: 3] = destination x.
- Depth, 4: FIFO entries; power of 2, ≥2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- position_x  in  3  this router's x coordinate; quasi-static.
- position_y  in  3  this router's y coordinate; quasi-static.
- data_in  in  FlitWidth  flit from the upstream link.
- data_in_valid  in  1  data_in carries a flit this cycle.
- data_in_ready  out  1  FIFO can accept a flit; equals ~full.
- request  out  5  one-hot or zero; bit k requests output port k. Ports: 0 North, 1 South, 2 West, 3 East, 4 Local.
- data_out  out  FlitWidth  FIFO front flit.
- grant  in  5  bit k = output-k arbiter grants this input.
- out_ready  in  5  bit k = output k's downstream can accept a flit.
- forwarding_head  out  1  head flit popped this cycle.
- forwarding_tail  out  1  tail flit popped this cycle.
- protocol_error  out  1  sticky; a non-head flit arrived at the front while no packet was open.

## Operation
FIFO:
- Circular buffer with wr_ptr, rd_ptr and count (log2(Depth)+1 bits). Pointers wrap modulo Depth.
- Push = data_in_valid & data_in_ready.
- Pop = fwd | drop, where:
  - fwd = |(request & grant & out_ready)
  - drop is defined under the FSM below.
- Push and pop in the same cycle leave count unchanged.
- No write-through bypass: when full, data_in_ready=0 even if a pop occurs that cycle.

XY route, computed from the front flit:
- dst_x > position_x → East.
- dst_x < position_x → West.
- Otherwise, dst_y > position_y → South.
- Otherwise, dst_y < position_y → North.
- Otherwise → Local.

Route FSM:
- IDLE:
  - If count > 0 and the front flit has head=1: request = route(front).
  - If count > 0 and head=0: request = 0, drop = 1, protocol_error <= 1.
  - On fwd with head=1 and tail=0: route_q <= route(front); go to ACTIVE.
  - On fwd with head=1 and tail=1: stay IDLE.
- ACTIVE:
  - request = route_q when count > 0, otherwise 0.
  - The head bit of body flits is ignored.
  - On fwd of a flit with tail=1: go to IDLE.
- forwarding_head = fwd & front.head & (state==IDLE).
- forwarding_tail = fwd & front.tail.
- A single-flit packet pulses both forwarding_head and forwarding_tail in the same cycle.
- grant or out_ready bits outside request are ignored; they never cause a pop.

## Timing
- Reset clears pointers and count, sets state IDLE, clears protocol_error. Registered state takes effect the cycle after rst is sampled.
- Outputs while rst is high: data_in_ready=0, request=0, forwarding_head/forwarding_tail=0, protocol_error=0.
- First cycle after rst deasserts: data_in_ready=1.
- Latency: a flit pushed at edge N is on data_out, with request valid, in cycle N+1. Route computation is zero-cycle combinational.
- Pop is zero-cycle: grant & out_ready in cycle N pops at the end of cycle N. The next flit is on data_out in N+1.
- Full throughput: 1 flit/cycle sustained with simultaneous push/pop.
- Reset mid-packet discards all buffered flits and the open route; the FSM returns to IDLE.
- request is stable from a head pop until the tail pop, except it drops to 0 while the FIFO is empty. The arbiter lock is unaffected.

## Test plan
1. Route check, position (2,2):
   - Single-flit (head=tail=1) to dst (3,0) → request=5'b01000 (East) in cycle N+1.
   - With grant[3]=out_ready[3]=1 → forwarding_head=forwarding_tail=1 for one cycle; FIFO empty; FSM IDLE.
2. 4-flit packet (head, 2 body, tail) to dst (2,0) → request=5'b00001 for all four flits. Drive grant[0]=1 with out_ready[0] toggling 1,0,1,1,1 → pops on ready cycles only; forwarding_tail on the 4th pop.
3. Fill: push 5 flits back-to-back with grant=0 → data_in_ready=0 after 4 pushes; 5th flit held upstream.
   - Enable grant → one pop per cycle; data_in_ready=1 the cycle after the first pop.
4. Route hold: packet to East with a body flit whose bits decode as a Local destination → request stays 5'b01000 until the tail pops.
5. Non-head flit (head=0, tail=0) arrives in IDLE → dropped in one cycle, request=0, protocol_error=1 and sticky until rst.
6. rst asserted with 2 flits of an open packet buffered → after reset count=0, request=0, data_in_ready=1. A new head to Local gives request=5'b10000.
